// File: rtl/ifetch_prefetch_pkg.sv
// Shared definitions for the instruction prefetch unit.
//   RESET_PC_DEFAULT : fetch PC used when the top is not overridden.
//   NOP_INSTR        : canonical NOP (addi x0,x0,0), used by downstream
//                      flush/bubble logic when it has to fill an empty slot.
//   fetch_state_e    : RUN while every response is fresh, FLUSH while stale
//                      responses from before a redirect are still arriving.
package ifetch_prefetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Parameterised synchronous FIFO with a synchronous clear.
//   clk, rst  : clock, asynchronous active-low reset
//   clear     : empties the FIFO; takes priority over push and pop
//   push      : write push_data (ignored when full unless popping too)
//   pop       : remove the head (ignored when empty)
//   head      : data at the head (storage resets to zero)
//   count     : current occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_en;
  logic             pop_en;

  assign pop_en  = pop && (count != '0);
  assign push_en = push && ((count != CNT_FULL) || pop_en);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[AW'(i)] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (pop_en) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push_en, pop_en})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ifetch_prefetch.sv
// Instruction prefetch unit feeding the IF/ID register.
//   clk, rst        : clock, asynchronous active-low reset
//   imem_req_*      : in-order fetch requests (valid/ready), word-aligned addr
//   imem_rsp_*      : in-order responses, no backpressure
//   redirect_*      : EX redirect; flushes the buffer, later responses for
//                     requests issued before it are discarded
//   out_*           : buffered {pc, instr} head towards decode (valid/ready)
// Issue is throttled so that in-flight requests plus buffered entries never
// exceed DEPTH, which keeps both FIFOs and all counters from overflowing.
module ifetch_prefetch
  import ifetch_prefetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
  input  logic        out_ready
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW:0]   OCC_MAX = (CW+1)'(DEPTH);

  fetch_state_e  state, state_next;
  logic [31:0]   fetch_pc;
  logic          issue_en;
  logic [CW-1:0] inflight;
  logic [CW-1:0] inflight_next;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] drop, drop_next;
  logic [CW:0]   occupancy;
  logic          req_fire;
  logic          rsp_drop;
  logic          rsp_keep;
  logic [31:0]   rsp_pc;
  logic [63:0]   out_head;
  logic          redirect_pc_unused;

  // Targets are word-aligned; the low bits carry no information.
  assign redirect_pc_unused = ^redirect_pc[1:0];

  assign occupancy      = {1'b0, inflight} + {1'b0, fifo_count};
  assign imem_req_valid = issue_en && (occupancy < OCC_MAX);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_drop = imem_rsp_valid && (state == ST_FLUSH);
  // A fresh response arriving with a redirect is discarded by the FIFO clear.
  assign rsp_keep = imem_rsp_valid && (state == ST_RUN);

  assign inflight_next = inflight + (req_fire ? CNT_ONE : '0)
                                  - (imem_rsp_valid ? CNT_ONE : '0);

  // The pc queue occupancy is the in-flight count; each response pops the
  // PC of the request it answers, so stale and fresh stay matched by order.
  fetch_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_pc_queue (
    .clk       (clk),
    .rst       (rst),
    .clear     (1'b0),
    .push      (req_fire),
    .push_data (fetch_pc),
    .pop       (imem_rsp_valid),
    .head      (rsp_pc),
    .count     (inflight)
  );

  fetch_fifo #(
    .WIDTH (64),
    .DEPTH (DEPTH)
  ) u_out_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (redirect_valid),
    .push      (rsp_keep),
    .push_data ({rsp_pc, imem_rsp_data}),
    .pop       (out_valid && out_ready),
    .head      (out_head),
    .count     (fifo_count)
  );

  assign out_valid    = (fifo_count != '0);
  assign out_pc       = out_head[63:32];
  assign out_instr    = out_head[31:0];
  assign out_pc_plus4 = out_pc + 32'd4;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_RUN;
      drop     <= '0;
      fetch_pc <= RESET_PC;
      issue_en <= 1'b0;
    end else begin
      state    <= state_next;
      drop     <= drop_next;
      issue_en <= 1'b1;
      if (redirect_valid) begin
        fetch_pc <= {redirect_pc[31:2], 2'b00};
      end else if (req_fire) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
    end
  end

  // Every request still outstanding after this cycle, including one accepted
  // in the redirect cycle itself, predates the redirect and is stale.
  always_comb begin
    state_next = state;
    drop_next  = drop;
    if (redirect_valid) begin
      drop_next = inflight_next;
    end else if (rsp_drop) begin
      drop_next = drop - CNT_ONE;
    end
    case (state)
      ST_RUN: begin
        if (redirect_valid && (drop_next != '0)) begin
          state_next = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (redirect_valid) begin
          state_next = (drop_next != '0) ? ST_FLUSH : ST_RUN;
        end else if (rsp_drop && (drop == CNT_ONE)) begin
          state_next = ST_RUN;
        end
      end
      default: state_next = ST_RUN;
    endcase
  end

endmodule
